// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a byte FIFO in front of the frame serialiser.
// Bytes enter through a valid/ready push port; tx idles high and is registered.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int BIT_PERIOD = CLK_FREQ / BAUDRATE,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BIT_PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    // Handshake: a byte is taken on any rising edge with valid_in && ready_out;
    // with ready_out low, valid_in has no effect and data_in must be held.

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          full, empty, push, pop, baud_done;

    state_e        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;

    always_comb begin
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty     = (wr_ptr_q == rd_ptr_q);
        baud_done = (baud_q == BW'(BIT_PERIOD - 1));
        push      = valid_in && !full;
        // The FSM only takes a byte when idle or when a stop bit is finishing.
        pop       = !empty && ((state_q == S_IDLE) ||
                               ((state_q == S_STOP) && baud_done));
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q[AW-1:0]];
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        idx_q   <= '0;
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                            idx_q   <= idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        // Chain straight into the next start bit with no idle gap.
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q[AW-1:0]];
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign ready_out  = !full;
    assign busy       = (state_q != S_IDLE) || !empty;
    assign fifo_count = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line-decoding monitor checks every frame against a
// queue of expected bytes; the main process drives pushes and timing checks.
module tb_uart_tx_fifo;
    localparam int BP  = 10;
    localparam int BP2 = 50_000_000 / 115200;

    logic       clk;
    logic       rst;
    logic [7:0] data_in, data2;
    logic       valid_in, valid2;
    logic       ready_out, ready2;
    logic       tx, tx2;
    logic       busy, busy2;
    logic [4:0] fifo_count, count2;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];
    longint     start_q[$];
    longint     start2_q[$];
    longint     t_acc;

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUDRATE(100)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx_fifo dut2 (
        .clk(clk), .rst(rst), .data_in(data2), .valid_in(valid2),
        .ready_out(ready2), .tx(tx2), .busy(busy2), .fifo_count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present a byte at a negedge and wait until the edge that accepts it.
    task automatic push(input bit which, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        if (which) begin data2 = b; valid2 = 1'b1; end
        else begin data_in = b; valid_in = 1'b1; end
        while (!(which ? ready2 : ready_out) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", n < 5000, 1);
        if (n < 5000) begin
            if (which) exp2_q.push_back(b);
            else exp_q.push_back(b);
            @(posedge clk);
            t_acc = $time;
        end else begin
            valid_in = 1'b0;
            valid2   = 1'b0;
        end
    endtask

    task automatic wait_idle(input bit which, input int max_cyc, output longint t_fall);
        int n = 0;
        while ((which ? busy2 : busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", which ? busy2 : busy, 0);
        t_fall = $time - 5;
    endtask

    // Monitor for the BIT_PERIOD=10 instance: every sample of a frame must match.
    initial begin
        int         e, bad;
        bit         aborted;
        logic [9:0] pat;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                start_q.push_back($time - 5);
                e       = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : 999;
                pat     = {1'b1, e[7:0], 1'b0};
                bad     = 0;
                aborted = 1'b0;
                got     = '0;
                for (int i = 0; i < 10 * BP; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx !== pat[i / BP]) bad++;
                    if (i / BP >= 1 && i / BP <= 8 && i % BP == BP / 2) got[i / BP - 1] = tx;
                end
                if (!aborted) begin
                    check("frame_byte", got, e);
                    check("frame_bad_samples", bad, 0);
                end
            end
        end
    end

    // Receiver for the default-parameter instance: mid-bit sampling.
    initial begin
        logic [7:0] r;
        bit         ok;
        forever begin
            @(negedge clk);
            if (!rst && tx2 === 1'b0) begin
                start2_q.push_back($time - 5);
                ok = 1'b1;
                repeat (BP2 / 2) @(negedge clk);
                if (tx2 !== 1'b0) ok = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    repeat (BP2) @(negedge clk);
                    r[b] = tx2;
                end
                repeat (BP2) @(negedge clk);
                if (tx2 !== 1'b1) ok = 1'b0;
                check("rx_framing", ok, 1);
                check("rx_byte", r, (exp2_q.size() > 0) ? int'(exp2_q.pop_front()) : 999);
            end
        end
    end

    initial begin
        longint s0, t_fall, t_r;
        int     n;
        rst = 1'b1; valid_in = 1'b0; valid2 = 1'b0; data_in = '0; data2 = '0;
        repeat (2) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_ready", ready_out, 1);
        check("reset_busy", busy, 0);
        check("reset_count", fifo_count, 0);
        check("reset_tx2", tx2, 1);
        check("reset_count2", count2, 0);
        rst = 1'b0;

        // Single byte
        start_q.delete();
        push(0, 8'hA5);
        @(negedge clk); valid_in = 1'b0;
        check("t1_busy_after_accept", busy, 1);
        check("t1_count_after_accept", fifo_count, 1);
        check("t1_tx_still_idle", tx, 1);
        @(negedge clk);
        check("t1_tx_start", tx, 0);
        check("t1_count_after_pop", fifo_count, 0);
        wait_idle(0, 300, t_fall);
        s0 = (start_q.size() > 0) ? start_q[0] : -1;
        check("t1_tx_latency", s0 - t_acc, 10);
        check("t1_busy_fall", t_fall - s0, 100 * 10);

        // Back-to-back
        start_q.delete();
        push(0, 8'h00);
        push(0, 8'hFF);
        @(negedge clk); valid_in = 1'b0;
        wait_idle(0, 500, t_fall);
        check("t2_frames", start_q.size(), 2);
        s0 = (start_q.size() > 0) ? start_q[0] : -1;
        check("t2_contiguous", ((start_q.size() > 1) ? start_q[1] : -1) - s0, 100 * 10);
        check("t2_total", t_fall - s0, 200 * 10);

        // Full FIFO
        start_q.delete();
        for (int j = 0; j < 17; j++) push(0, 8'($urandom_range(0, 255)));
        @(negedge clk);
        data_in = 8'hEE;
        check("t3_count_full", fifo_count, 16);
        check("t3_ready_full", ready_out, 0);
        repeat (20) @(negedge clk);
        check("t3_count_ignored", fifo_count, 16);
        n = 0;
        while (!ready_out && n < 500) begin
            @(negedge clk);
            n++;
        end
        t_r = $time - 5;
        valid_in = 1'b0;
        s0 = (start_q.size() > 0) ? start_q[0] : -1;
        check("t3_ready_rise", t_r - s0, 100 * 10);
        check("t3_count_after_pop", fifo_count, 15);
        wait_idle(0, 3000, t_fall);
        check("t3_drained", exp_q.size(), 0);

        // Simultaneous push/pop across pointer wrap
        start_q.delete();
        for (int j = 0; j < 4; j++) push(0, 8'($urandom_range(0, 255)));
        @(negedge clk); valid_in = 1'b0;
        check("t4_count_initial", fifo_count, 3);
        s0 = (start_q.size() > 0) ? start_q[0] : 0;
        for (int j = 1; j <= 36; j++) begin
            while ($time < s0 + j * 1000 - 5) @(negedge clk);
            data_in  = 8'($urandom_range(0, 255));
            valid_in = 1'b1;
            check("t4_ready_at_pop", ready_out, 1);
            exp_q.push_back(data_in);
            @(negedge clk);
            valid_in = 1'b0;
            check("t4_count_pushpop", fifo_count, 3);
        end
        wait_idle(0, 6000, t_fall);
        check("t4_drained", exp_q.size(), 0);
        check("t4_frames", start_q.size(), 40);

        // Reset mid-frame
        start_q.delete();
        push(0, 8'h3C);
        for (int j = 0; j < 5; j++) push(0, 8'($urandom_range(0, 255)));
        @(negedge clk); valid_in = 1'b0;
        s0 = (start_q.size() > 0) ? start_q[0] : 0;
        while ($time < s0 + 455) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_tx_async", tx, 1);
        check("t5_count", fifo_count, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", ready_out, 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_q.delete();
        push(0, 8'($urandom_range(0, 255)));
        @(negedge clk); valid_in = 1'b0;
        wait_idle(0, 300, t_fall);
        s0 = (start_q.size() > 0) ? start_q[0] : -1;
        check("t5_latency_after_reset", s0 - t_acc, 10);
        check("t5_drained", exp_q.size(), 0);

        // Default parameters into a line receiver
        start2_q.delete();
        push(1, 8'h55);
        push(1, 8'h0D);
        push(1, 8'h7E);
        @(negedge clk); valid2 = 1'b0;
        wait_idle(1, 15000, t_fall);
        check("t6_frames", start2_q.size(), 3);
        for (int j = 1; j < 3; j++)
            check("t6_frame_period",
                  ((start2_q.size() > j) ? start2_q[j] - start2_q[j - 1] : -1), 10 * BP2 * 10);
        check("t6_drained", exp2_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
